// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: checks init order, refresh interval, tRCAR and CAS latency.
// Optional init-sequence FSM is built when SDRAM_MON_INIT_CHECK_EN is defined.
module sdram_cmd_monitor #(
   parameter int RFSH_MAX  = 1024,
   parameter int TRCAR     = 7,
   parameter int INIT_NOP  = 10000,
   parameter int INIT_AR   = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 sdram_clk,
   input  logic                 sdram_resetn,
   input  logic                 sdram_en,
   input  logic                 sdram_cs_n,
   input  logic                 sdram_ras_n,
   input  logic                 sdram_cas_n,
   input  logic                 sdram_we_n,
   input  logic [2:0]           cfg_cas,
   input  logic                 clr_i,
   output logic                 init_done,
   output logic [4:0]           err_flags,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [15:0]          rfsh_cnt
);

   logic [2:0] cmd;
   logic       is_nop;
   logic       is_ar;
   logic       ev_order;
   logic       ev_rw;

   assign cmd    = {sdram_ras_n, sdram_cas_n, sdram_we_n};
   assign is_nop = sdram_cs_n | (cmd == 3'b111);
   assign is_ar  = !sdram_cs_n & (cmd == 3'b001);

`ifdef SDRAM_MON_INIT_CHECK_EN
   localparam int NW = $clog2(INIT_NOP + 1);
   localparam int AW = $clog2(INIT_AR + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_NOP, S_WAIT_PRE, S_AR, S_WAIT_MRS, S_DONE, S_FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [NW-1:0] nop_cnt_q, nop_cnt_d;
   logic [AW-1:0] ar_cnt_q, ar_cnt_d;
   logic          is_pre, is_mrs, is_rw;

   assign is_pre = !sdram_cs_n & (cmd == 3'b010);
   assign is_mrs = !sdram_cs_n & (cmd == 3'b000);
   assign is_rw  = !sdram_cs_n & ((cmd == 3'b101) | (cmd == 3'b100));

   // Init FSM state and its NOP / AUTOREFRESH counters
   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state_q   <= S_IDLE;
         nop_cnt_q <= '0;
         ar_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         nop_cnt_q <= nop_cnt_d;
         ar_cnt_q  <= ar_cnt_d;
      end
   end

   // Init sequence next state; any out-of-order command lands in FAIL
   always_comb begin
      state_d   = state_q;
      nop_cnt_d = nop_cnt_q;
      ar_cnt_d  = ar_cnt_q;
      ev_order  = 1'b0;
      if (!sdram_en) begin
         state_d   = S_IDLE;
         nop_cnt_d = '0;
         ar_cnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d   = S_WAIT_NOP;
               nop_cnt_d = '0;
               ar_cnt_d  = '0;
            end
            S_WAIT_NOP: begin
               if (!is_nop) begin
                  state_d  = S_FAIL;
                  ev_order = 1'b1;
               end else if (nop_cnt_q == NW'(INIT_NOP - 1)) begin
                  state_d = S_WAIT_PRE;
               end else begin
                  nop_cnt_d = nop_cnt_q + NW'(1);
               end
            end
            S_WAIT_PRE: begin
               if (is_pre) begin
                  state_d = S_AR;
               end else if (!is_nop) begin
                  state_d  = S_FAIL;
                  ev_order = 1'b1;
               end
            end
            S_AR: begin
               if (is_ar) begin
                  if (ar_cnt_q == AW'(INIT_AR - 1))
                     state_d = S_WAIT_MRS;
                  else
                     ar_cnt_d = ar_cnt_q + AW'(1);
               end else if (!is_nop && !is_pre) begin
                  state_d  = S_FAIL;
                  ev_order = 1'b1;
               end
            end
            S_WAIT_MRS: begin
               if (is_mrs) begin
                  state_d = S_DONE;
               end else if (!is_nop) begin
                  state_d  = S_FAIL;
                  ev_order = 1'b1;
               end
            end
            S_DONE, S_FAIL: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign ev_rw     = is_rw & (state_q != S_DONE);
   assign init_done = (state_q == S_DONE);
`else
   logic en_q;

   // Without the init check, init is just the registered enable
   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) en_q <= 1'b0;
      else               en_q <= sdram_en;
   end

   assign init_done = en_q;
   assign ev_order  = 1'b0;
   assign ev_rw     = 1'b0;
`endif

   logic [15:0]          rint_q, rint_d;
   logic                 arm_q, arm_d;
   logic [15:0]          trc_q, trc_d;
   logic                 cas_bad_q, cas_bad_now;
   logic                 ev_late, ev_trc, ev_cas;
   logic [4:0]           events;
   logic [4:0]           flags_q, flags_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]          rfsh_q, rfsh_d;

   assign cas_bad_now = sdram_en & (cfg_cas != 3'd2) & (cfg_cas != 3'd3);
   assign ev_cas      = cas_bad_now & !cas_bad_q;
   assign ev_trc      = (trc_q != 16'd0) & !is_nop;
   assign events      = {ev_rw, ev_cas, ev_trc, ev_late, ev_order};

   // Checker next state: refresh interval, tRCAR window, flags and counts
   always_comb begin
      rint_d  = rint_q;
      arm_d   = arm_q;
      ev_late = 1'b0;
      if (!init_done || is_ar) begin
         rint_d = 16'd0;
         arm_d  = 1'b1;
      end else begin
         if (rint_q != 16'hFFFF) rint_d = rint_q + 16'd1;
         if (arm_q && (rint_d >= 16'(RFSH_MAX))) begin
            ev_late = 1'b1;
            arm_d   = 1'b0;
         end
      end
      if (is_ar)                trc_d = 16'(TRCAR - 1);
      else if (trc_q != 16'd0)  trc_d = trc_q - 16'd1;
      else                      trc_d = 16'd0;
      flags_d = (clr_i ? 5'd0 : flags_q) | events;
      cnt_d   = clr_i ? '0 : cnt_q;
      if ((|events) && (cnt_d != '1)) cnt_d = cnt_d + ERR_CNT_W'(1);
      rfsh_d  = rfsh_q + {15'd0, is_ar};
   end

   // Checker state registers
   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         rint_q    <= 16'd0;
         arm_q     <= 1'b1;
         trc_q     <= 16'd0;
         cas_bad_q <= 1'b0;
         flags_q   <= 5'd0;
         cnt_q     <= '0;
         rfsh_q    <= 16'd0;
      end else begin
         rint_q    <= rint_d;
         arm_q     <= arm_d;
         trc_q     <= trc_d;
         cas_bad_q <= cas_bad_now;
         flags_q   <= flags_d;
         cnt_q     <= cnt_d;
         rfsh_q    <= rfsh_d;
      end
   end

   assign err_flags = flags_q;
   assign err_cnt   = cnt_q;
   assign rfsh_cnt  = rfsh_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// tb_sdram_cmd_monitor: directed checks for sdram_cmd_monitor.
// Covers the default build and, with SDRAM_MON_INIT_CHECK_EN, the init FSM.
module tb_sdram_cmd_monitor;

   localparam int RFSH_MAX  = 100;
   localparam int TRCAR     = 7;
   localparam int INIT_NOP  = 16;
   localparam int INIT_AR   = 2;
   localparam int ERR_CNT_W = 8;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_AR  = 4'b0001;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_MRS = 4'b0000;
   localparam logic [3:0] C_ACT = 4'b0011;

   logic                 clk = 1'b0;
   logic                 resetn, en, cs_n, ras_n, cas_n, we_n, clr;
   logic [2:0]           cfg_cas;
   logic                 init_done;
   logic [4:0]           err_flags;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic [15:0]          rfsh_cnt;

   int checks = 0;
   int errors = 0;
   int rfsh_exp = 0;

   always #5 clk = ~clk;

   sdram_cmd_monitor #(
      .RFSH_MAX(RFSH_MAX), .TRCAR(TRCAR), .INIT_NOP(INIT_NOP),
      .INIT_AR(INIT_AR), .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .sdram_clk(clk), .sdram_resetn(resetn), .sdram_en(en),
      .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n),
      .sdram_we_n(we_n), .cfg_cas(cfg_cas), .clr_i(clr),
      .init_done(init_done), .err_flags(err_flags), .err_cnt(err_cnt),
      .rfsh_cnt(rfsh_cnt)
   );

   task automatic cyc(input logic [3:0] c);
      {cs_n, ras_n, cas_n, we_n} = c;
      @(posedge clk);
      #1;
      if (c == C_AR && resetn) rfsh_exp++;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) cyc(C_NOP);
   endtask

   task automatic test_reset;
      resetn = 1'b0; en = 1'b0; clr = 1'b0; cfg_cas = 3'd3;
      nops(2);
      resetn = 1'b1;
      rfsh_exp = 0;
      checks++;
      if (init_done !== 1'b0) begin
         errors++; $display("FAIL reset_init_done: got %0b exp 0", init_done);
      end
      checks++;
      if (err_flags !== 5'd0) begin
         errors++; $display("FAIL reset_flags: got %b exp 00000", err_flags);
      end
      checks++;
      if (err_cnt !== 8'd0 || rfsh_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_counts: got err_cnt %0d rfsh_cnt %0d exp 0 0",
                  err_cnt, rfsh_cnt);
      end
   endtask

`ifdef SDRAM_MON_INIT_CHECK_EN
   task automatic legal_init;
      en = 1'b1;
      cyc(C_NOP);
      nops(INIT_NOP);
      cyc(C_PRE); cyc(C_NOP);
      cyc(C_AR);  nops(7);
      cyc(C_AR);  nops(7);
   endtask

   task automatic test_init_fail;
      en = 1'b1;
      cyc(C_NOP);
      nops(4);
      cyc(C_AR);
      checks++;
      if (err_flags !== 5'b00001 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL init_order: got flags %b cnt %0d exp 00001 1",
                  err_flags, err_cnt);
      end
      nops(20); cyc(C_PRE); nops(8); cyc(C_AR); nops(8); cyc(C_MRS);
      checks++;
      if (init_done !== 1'b0 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL fail_sticky: got init_done %0b cnt %0d exp 0 1",
                  init_done, err_cnt);
      end
      en = 1'b0;
      cyc(C_NOP);
      clr = 1'b1; cyc(C_NOP); clr = 1'b0;
   endtask

   task automatic test_init;
      legal_init();
      checks++;
      if (init_done !== 1'b0) begin
         errors++; $display("FAIL init_pre_mrs: got %0b exp 0", init_done);
      end
      cyc(C_MRS);
      checks++;
      if (init_done !== 1'b1 || err_flags !== 5'd0 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL init_legal: got done %0b flags %b cnt %0d exp 1 00000 0",
                  init_done, err_flags, err_cnt);
      end
   endtask
`else
   task automatic test_init;
      en = 1'b1;
      cyc(C_RD);
      checks++;
      if (init_done !== 1'b1) begin
         errors++; $display("FAIL en_init_done: got %0b exp 1", init_done);
      end
      cyc(C_WR);
      checks++;
      if (err_flags !== 5'd0 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rw_no_init_check: got flags %b cnt %0d exp 00000 0",
                  err_flags, err_cnt);
      end
   endtask
`endif

   task automatic test_refresh;
      cyc(C_AR);
      nops(RFSH_MAX - 1);
      checks++;
      if (err_flags[1] !== 1'b0) begin
         errors++; $display("FAIL rfsh_early: got %0b exp 0", err_flags[1]);
      end
      cyc(C_NOP);
      checks++;
      if (err_flags !== 5'b00010 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL rfsh_late: got flags %b cnt %0d exp 00010 1",
                  err_flags, err_cnt);
      end
      nops(50);
      checks++;
      if (err_cnt !== 8'd1) begin
         errors++; $display("FAIL rfsh_once: got cnt %0d exp 1", err_cnt);
      end
      clr = 1'b1; cyc(C_AR); clr = 1'b0;
      nops(RFSH_MAX);
      checks++;
      if (err_flags !== 5'b00010 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL rfsh_rearm: got flags %b cnt %0d exp 00010 1",
                  err_flags, err_cnt);
      end
   endtask

   task automatic test_trcar;
      clr = 1'b1; cyc(C_AR); clr = 1'b0;
      nops(TRCAR - 2);
      cyc(C_ACT);
      checks++;
      if (err_flags !== 5'b00100 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL trcar_t6: got flags %b cnt %0d exp 00100 1",
                  err_flags, err_cnt);
      end
      clr = 1'b1; cyc(C_AR); clr = 1'b0;
      nops(TRCAR - 1);
      cyc(C_ACT);
      checks++;
      if (err_flags !== 5'd0 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL trcar_t7: got flags %b cnt %0d exp 00000 0",
                  err_flags, err_cnt);
      end
   endtask

   task automatic test_back_to_back;
      cyc(C_AR);
      cyc(C_AR);
      checks++;
      if (err_flags !== 5'b00100 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL ar_b2b: got flags %b cnt %0d exp 00100 1",
                  err_flags, err_cnt);
      end
   endtask

   task automatic test_cas;
      clr = 1'b1; cyc(C_NOP); clr = 1'b0;
      cfg_cas = 3'd1;
      nops(10);
      cfg_cas = 3'd3;
      checks++;
      if (err_flags !== 5'b01000 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL cas_once: got flags %b cnt %0d exp 01000 1",
                  err_flags, err_cnt);
      end
      cfg_cas = 3'd2;
      nops(2);
      cfg_cas = 3'd0;
      cyc(C_NOP);
      cfg_cas = 3'd3;
      checks++;
      if (err_cnt !== 8'd2) begin
         errors++; $display("FAIL cas_reentry: got cnt %0d exp 2", err_cnt);
      end
   endtask

   task automatic test_clr_collision;
      cyc(C_AR);
      clr = 1'b1; cyc(C_ACT); clr = 1'b0;
      checks++;
      if (err_flags !== 5'b00100 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL clr_vs_err: got flags %b cnt %0d exp 00100 1",
                  err_flags, err_cnt);
      end
   endtask

   task automatic test_saturate;
      nops(TRCAR + 1);
      for (int i = 0; i < 260; i++) cyc(C_AR);
      checks++;
      if (err_cnt !== 8'hFF) begin
         errors++; $display("FAIL err_sat: got cnt %0d exp 255", err_cnt);
      end
      checks++;
      if (rfsh_cnt !== 16'(rfsh_exp)) begin
         errors++;
         $display("FAIL rfsh_count: got %0d exp %0d", rfsh_cnt, rfsh_exp);
      end
   endtask

   task automatic test_reset_mid;
      resetn = 1'b0;
      cyc(C_NOP);
      checks++;
      if (init_done !== 1'b0 || err_flags !== 5'd0 ||
          err_cnt !== 8'd0 || rfsh_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: got done %0b flags %b cnt %0d rfsh %0d exp 0",
                  init_done, err_flags, err_cnt, rfsh_cnt);
      end
      resetn = 1'b1;
      cyc(C_NOP);
      checks++;
`ifdef SDRAM_MON_INIT_CHECK_EN
      if (init_done !== 1'b0) begin
         errors++; $display("FAIL restart_init: got %0b exp 0", init_done);
      end
`else
      if (init_done !== 1'b1) begin
         errors++; $display("FAIL restart_init: got %0b exp 1", init_done);
      end
`endif
      en = 1'b0;
      cfg_cas = 3'd5;
      nops(3);
      cfg_cas = 3'd3;
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++; $display("FAIL cas_when_off: got cnt %0d exp 0", err_cnt);
      end
   endtask

   initial begin
      test_reset();
`ifdef SDRAM_MON_INIT_CHECK_EN
      test_init_fail();
`endif
      test_init();
      test_refresh();
      test_trcar();
      test_back_to_back();
      test_cas();
      test_clr_collision();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_monitor.md
# sdram_cmd_monitor

Synthesizable SDRAM command-bus monitor that sits beside the SDRAM controller on the `sdram_clk` domain and checks the command stream it drives. It checks the power-up init sequence, the auto-refresh interval, the refresh-to-command gap (tRCAR) and CAS-latency legality. Violations are reported as sticky flags, a saturating error count and a refresh count readable by software. All limits are parameters, so one block covers every SDRAM grade in the design.

## Interface
Parameters:
- `RFSH_MAX`, 1024: maximum cycles allowed between AUTOREFRESH commands once init is done.
- `TRCAR`, 7: cycles from AUTOREFRESH to the next permitted non-NOP command.
- `INIT_NOP`, 10000: consecutive NOP cycles required after `sdram_en` rises.
- `INIT_AR`, 2: AUTOREFRESH commands required during init.
- `ERR_CNT_W`, 8: width of `err_cnt`.

Ports:
- `sdram_clk` in 1: sole clock; everything is sampled on its rising edge.
- `sdram_resetn` in 1: synchronous reset, active low.
- `sdram_en` in 1: controller enable; a rising edge starts the init check.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` in 1 each: monitored command bus.
- `cfg_cas` in 3: programmed CAS latency.
- `clr_i` in 1: synchronous clear of `err_flags` and `err_cnt`.
- `init_done` out 1: init sequence has completed correctly.
- `err_flags` out 5: sticky flags; [0] INIT_ORDER, [1] RFSH_LATE, [2] TRCAR, [3] CAS_INVALID, [4] RW_BEFORE_INIT.
- `err_cnt` out ERR_CNT_W: saturating count of error events.
- `rfsh_cnt` out 16: count of AUTOREFRESH commands since reset; wraps.

## Operation
Command decode, with `{ras_n,cas_n,we_n}` qualified by `cs_n`=0:
- `cs_n`=1 or 111 is NOP.
- 010 is PRECHARGE.
- 001 is AUTOREFRESH.
- 101 is READ.
- 100 is WRITE.
- 000 is MRS.
- 011 is ACTIVE.

Init FSM states: IDLE, WAIT_NOP, WAIT_PRE, AR, WAIT_MRS, DONE, FAIL.
- Any state goes to IDLE whenever `sdram_en`=0.
- IDLE→WAIT_NOP on `sdram_en`=1.
- WAIT_NOP: count NOP cycles. After INIT_NOP of them, go to WAIT_PRE. Any non-NOP before then sets INIT_ORDER and goes to FAIL.
- WAIT_PRE: NOP stays. PRECHARGE goes to AR. Any other command goes to FAIL with INIT_ORDER.
- AR: NOP and PRECHARGE are allowed. Count AUTOREFRESH; the INIT_AR-th one goes to WAIT_MRS. Any other command goes to FAIL with INIT_ORDER.
- WAIT_MRS: NOP allowed. MRS goes to DONE. Any other command goes to FAIL with INIT_ORDER.
- READ or WRITE in any state other than DONE additionally sets RW_BEFORE_INIT.
- `init_done` = (state==DONE).

Refresh-interval checker (active only in DONE):
- The 16-bit interval counter clears on AUTOREFRESH and increments otherwise.
- When it reaches RFSH_MAX with no AUTOREFRESH in that cycle, RFSH_LATE fires once. It does not re-fire until the next AUTOREFRESH.

tRCAR checker (active in all states):
- If AUTOREFRESH occurs at cycle t, any non-NOP command in t+1..t+TRCAR-1 sets TRCAR. This includes a back-to-back AUTOREFRESH.
- A command at t+TRCAR is legal.

CAS checker:
- While `sdram_en`=1, `cfg_cas` must be 2 or 3.
- CAS_INVALID fires once on each entry into an illegal value, not on every cycle it stays illegal.

Counting:
- `err_cnt` increments by exactly 1 in any cycle with one or more error events.
- It saturates at all-ones.
- `rfsh_cnt` increments on every AUTOREFRESH, in any state.

## Timing
- Reset values: `init_done`=0, `err_flags`=0, `err_cnt`=0, `rfsh_cnt`=0, FSM=IDLE, all internal counters=0.
- Latency: a command sampled at edge n updates flags, counters and state at edge n+1.
- If `clr_i` and an error event fall in the same cycle, the error wins: the corresponding flag ends at 1 and `err_cnt` ends at 1.
- Reset asserted mid-init returns the FSM to IDLE at the next edge. The init check restarts only on `sdram_en`=1 after reset is released.
- FAIL is sticky until `sdram_en` falls.

## Configuration
Macro `SDRAM_MON_INIT_CHECK_EN`:
- Defined: the init FSM and error bits [0] and [4] are present as described above.
- Undefined: the FSM is removed, `init_done` is `sdram_en` registered by one cycle, `err_flags[0]` and `err_flags[4]` are tied to 0, and the refresh-interval checker is enabled by that `init_done`.

## Test plan
- Legal init with INIT_NOP=16, INIT_AR=2: 16 NOP, PRE, NOP, AR, NOP×7, AR, NOP×7, MRS -> `init_done`=1 one cycle after MRS; `err_flags`=0.
- AUTOREFRESH at NOP cycle 5 of WAIT_NOP -> `err_flags[0]`=1, `err_cnt`=1, FSM in FAIL; dropping `sdram_en` then reissuing the legal init -> `init_done`=1.
- After init with RFSH_MAX=100: 100 cycles without AR -> `err_flags[1]`=1 and `err_cnt`=1 once; 50 further cycles -> `err_cnt` stays 1.
- AR at t, ACTIVE at t+6 (TRCAR=7) -> `err_flags[2]`=1; AR at t, ACTIVE at t+7 -> no error.
- `cfg_cas`=3→1 held for 10 cycles -> `err_cnt`+1 only; `clr_i` pulsed in the same cycle as a TRCAR error -> `err_flags`=5'b00100, `err_cnt`=1.
- Build without `SDRAM_MON_INIT_CHECK_EN`: READ immediately after `sdram_en` rises -> `err_flags[4]`=0 and `init_done`=1 one cycle after `sdram_en` rises.
